// File: rtl/dsram_pkg.sv
// Shared types and helpers for the word-enable data SRAM model.
// Holds the controller state encoding and the legal read-latency range.
package dsram_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    function automatic int words(input int data_width, input int word_width);
        return data_width / word_width;
    endfunction

endpackage

// File: rtl/dsram_wbe_array.sv
// Raw ENTRIES x DATA_WIDTH storage with per-word write enables and a registered read.
// Read data lands one edge after re; a same-edge write is not visible (read-old-data); no backpressure.
module dsram_wbe_array
    import dsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 256,
    parameter int WORD_WIDTH = 32,
    localparam int WORDS     = words(DATA_WIDTH, WORD_WIDTH)
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [WORDS-1:0]      we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdat,
    output logic [DATA_WIDTH-1:0] rdat
);

    localparam int ENTRIES = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (re) begin
            rdat <= mem[addr];
        end
        for (int w = 0; w < WORDS; w++) begin
            if (we[w]) begin
                mem[addr][w*WORD_WIDTH +: WORD_WIDTH] <= wdat[w*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

endmodule

// File: rtl/dsram_wbe.sv
// Single-port L1 data SRAM: word-enable writes, full-line fills, post-reset init sweep.
// Read data after RD_LAT edges past acceptance; req_ready is low during reset and the sweep, then always high.
module dsram_wbe
    import dsram_pkg::*;
#(
    parameter int ADDR_WIDTH                  = 13,
    parameter int DATA_WIDTH                  = 256,
    parameter int WORD_WIDTH                  = 32,
    parameter int RD_LAT                      = 1,
    parameter bit INIT_ON_RESET               = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int WORDS                      = words(DATA_WIDTH, WORD_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] a,
    input  logic                  read,
    input  logic                  write,
    input  logic                  fill,
    input  logic [WORDS-1:0]      be,
    input  logic [DATA_WIDTH-1:0] wd,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  rd_valid,
    output logic                  init_done
);

    if (DATA_WIDTH % WORD_WIDTH != 0) begin : g_bad_word
        $error("dsram_wbe: DATA_WIDTH must be a multiple of WORD_WIDTH");
    end
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("dsram_wbe: RD_LAT must be 1 or 2");
    end

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_we;
    logic                  accept;

    logic                  arr_re;
    logic [WORDS-1:0]      arr_we;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_WIDTH-1:0] arr_wdat;
    logic [DATA_WIDTH-1:0] arr_rdat;

    logic                  rd0_vld;
    logic                  pipe_vld;
    logic [DATA_WIDTH-1:0] pipe_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = INIT_ON_RESET;
                if (!INIT_ON_RESET || cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Gating with rst keeps a request presented in the reset cycle from touching the array.
    assign req_ready = (state_q == ST_RUN) && !rst;
    assign init_done = (state_q == ST_RUN);
    assign accept    = req_valid && req_ready;

    always_comb begin
        arr_re   = 1'b0;
        arr_we   = '0;
        arr_addr = cnt_q;
        arr_wdat = INIT_VALUE;
        if (state_q == ST_INIT && !rst) begin
            arr_we = {WORDS{init_we}};
        end else if (accept) begin
            arr_addr = a;
            arr_wdat = wd;
            arr_re   = read;
            if (fill) begin
                arr_we = '1;
            end else if (write) begin
                arr_we = be;
            end
        end
    end

    dsram_wbe_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_array (
        .clk  (clk),
        .re   (arr_re),
        .we   (arr_we),
        .addr (arr_addr),
        .wdat (arr_wdat),
        .rdat (arr_rdat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd0_vld <= 1'b0;
        end else begin
            rd0_vld <= accept && read;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic                  rd1_vld;
        logic [DATA_WIDTH-1:0] rd1_dat;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd1_vld <= 1'b0;
                rd1_dat <= '0;
            end else begin
                rd1_vld <= rd0_vld;
                if (rd0_vld) begin
                    rd1_dat <= arr_rdat;
                end
            end
        end

        assign pipe_vld = rd1_vld;
        assign pipe_dat = rd1_dat;
    end else begin : g_lat1
        assign pipe_vld = rd0_vld;
        assign pipe_dat = arr_rdat;
    end

    // rd only loads on a matured read so it holds its value through idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd       <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pipe_vld;
            if (pipe_vld) begin
                rd <= pipe_dat;
            end
        end
    end

endmodule

// File: tb/tb_dsram_wbe.sv
// Bench for dsram_wbe: one RD_LAT=1 and one RD_LAT=2 instance share stimulus and a line-level memory model.
module tb_dsram_wbe;

    typedef logic [255:0] line_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid, read, write, fill;
    logic [3:0] a;
    logic [7:0] be;
    line_t      wd;

    logic  rdy1, rdy2, rv1, rv2, id1, id2;
    line_t rd1, rd2;

    line_t mem_m [16];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    dsram_wbe #(.ADDR_WIDTH(4), .DATA_WIDTH(256), .WORD_WIDTH(32), .RD_LAT(1),
                .INIT_ON_RESET(1'b1), .INIT_VALUE('0)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .a(a),
        .read(read), .write(write), .fill(fill), .be(be), .wd(wd),
        .rd(rd1), .rd_valid(rv1), .init_done(id1));

    dsram_wbe #(.ADDR_WIDTH(4), .DATA_WIDTH(256), .WORD_WIDTH(32), .RD_LAT(2),
                .INIT_ON_RESET(1'b1), .INIT_VALUE('0)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2), .a(a),
        .read(read), .write(write), .fill(fill), .be(be), .wd(wd),
        .rd(rd2), .rd_valid(rv2), .init_done(id2));

    // Line after an accepted request: fill replaces everything, write replaces enabled words.
    function automatic line_t merge(line_t old, line_t d, logic [7:0] b, logic w, logic f);
        line_t r = old;
        if (f) return d;
        if (w) begin
            for (int i = 0; i < 8; i++) begin
                if (b[i]) r[i*32 +: 32] = d[i*32 +: 32];
            end
        end
        return r;
    endfunction

    function automatic line_t rand_line();
        line_t r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        read = 1'b0; write = 1'b0; fill = 1'b0;
        a = 'x; be = 'x; wd = 'x;
    endtask

    task automatic drive(input logic r, input logic w, input logic f,
                         input logic [3:0] ad, input logic [7:0] b, input line_t d);
        req_valid = 1'b1;
        read = r; write = w; fill = f;
        a = ad; be = b; wd = d;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!rdy1 && n < 100) begin
            step();
            n++;
        end
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
    endtask

    task automatic write_line(input logic [3:0] ad, input logic w, input logic f,
                              input logic [7:0] b, input line_t d);
        drive(1'b0, w, f, ad, b, d);
        step();
        idle();
        mem_m[ad] = merge(mem_m[ad], d, b, w, f);
    endtask

    task automatic read_one(input logic [3:0] ad, output line_t d1, output logic v1,
                            output line_t d2, output logic v2);
        drive(1'b1, 1'b0, 1'b0, ad, 8'h00, '0);
        step();
        idle();
        step();
        d1 = rd1; v1 = rv1;
        step();
        d2 = rd2; v2 = rv2;
    endtask

    task automatic test_reset();
        int n;
        line_t d1, d2;
        logic v1, v2;
        step();
        do_reset();
        checks++;
        if ({rdy1, rdy2, rv1, rv2, id1, id2} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b%b rv=%b%b done=%b%b want all 0", rdy1, rdy2, rv1, rv2, id1, id2);
        end
        checks++;
        if (rd1 !== '0 || rd2 !== '0) begin
            errors++;
            $display("FAIL reset_rd: got %h / %h want 0", rd1, rd2);
        end
        wait_init(n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL init_len: got %0d cycles want 16", n);
        end
        checks++;
        if ({rdy2, id1, id2} !== 3'b111) begin
            errors++;
            $display("FAIL init_done: got rdy2=%b done=%b%b want 1 11", rdy2, id1, id2);
        end
        for (int i = 0; i < 16; i++) begin
            read_one(4'(i), d1, v1, d2, v2);
            checks++;
            if (!v1 || !v2 || d1 !== mem_m[i] || d2 !== mem_m[i]) begin
                errors++;
                $display("FAIL init_read[%0d]: got v=%b%b %h / %h want v=11 %h", i, v1, v2, d1, d2, mem_m[i]);
            end
        end
    endtask

    task automatic test_word_write();
        line_t d1, d2, exp;
        logic v1, v2;
        exp = {{5{32'hA5A5A5A5}}, 32'h11111111, 32'hA5A5A5A5, 32'h11111111};
        write_line(4'd3, 1'b0, 1'b1, 8'h00, {8{32'hA5A5A5A5}});
        write_line(4'd3, 1'b1, 1'b0, 8'b0000_0101, {8{32'h11111111}});
        read_one(4'd3, d1, v1, d2, v2);
        checks++;
        if (!v1 || !v2 || d1 !== exp || d2 !== exp) begin
            errors++;
            $display("FAIL word_write: got v=%b%b %h / %h want %h", v1, v2, d1, d2, exp);
        end
    endtask

    task automatic test_fill_priority();
        line_t d1, d2, exp;
        logic v1, v2;
        exp = {8{32'hDEADBEEF}};
        write_line(4'd5, 1'b1, 1'b1, 8'h00, exp);
        read_one(4'd5, d1, v1, d2, v2);
        checks++;
        if (!v1 || !v2 || d1 !== exp || d2 !== exp) begin
            errors++;
            $display("FAIL fill_priority: got %h / %h want %h", d1, d2, exp);
        end
        write_line(4'd5, 1'b1, 1'b0, 8'h00, rand_line());
        drive(1'b0, 1'b0, 1'b0, 4'd5, 8'hFF, rand_line());
        step();
        idle();
        read_one(4'd5, d1, v1, d2, v2);
        checks++;
        if (!v1 || !v2 || d1 !== exp || d2 !== exp) begin
            errors++;
            $display("FAIL empty_be_noop: got %h / %h want %h", d1, d2, exp);
        end
    endtask

    task automatic test_back_to_back();
        line_t h1, h2;
        logic e1, e2;
        for (int i = 0; i < 3; i++) write_line(4'(i), 1'b0, 1'b1, 8'h00, rand_line());
        h1 = rd1; h2 = rd2;
        for (int k = 0; k < 6; k++) begin
            if (k < 3) drive(1'b1, 1'b0, 1'b0, 4'(k), 8'h00, '0);
            else idle();
            step();
            e1 = (k >= 1 && k <= 3);
            e2 = (k >= 2 && k <= 4);
            if (e1) h1 = mem_m[k-1];
            if (e2) h2 = mem_m[k-2];
            checks++;
            if (rv1 !== e1 || rd1 !== h1) begin
                errors++;
                $display("FAIL b2b_lat1 k=%0d: got v=%b %h want v=%b %h", k, rv1, rd1, e1, h1);
            end
            checks++;
            if (rv2 !== e2 || rd2 !== h2) begin
                errors++;
                $display("FAIL b2b_lat2 k=%0d: got v=%b %h want v=%b %h", k, rv2, rd2, e2, h2);
            end
        end
    endtask

    task automatic test_hazard();
        line_t old_l, new_l;
        old_l = rand_line();
        new_l = rand_line();
        write_line(4'd7, 1'b0, 1'b1, 8'h00, old_l);
        drive(1'b1, 1'b0, 1'b1, 4'd7, 8'h00, new_l);
        step();
        drive(1'b1, 1'b0, 1'b0, 4'd7, 8'h00, '0);
        step();
        idle();
        mem_m[7] = new_l;
        checks++;
        if (!rv1 || rd1 !== old_l) begin
            errors++;
            $display("FAIL hazard_old_lat1: got v=%b %h want %h", rv1, rd1, old_l);
        end
        step();
        checks++;
        if (!rv1 || rd1 !== new_l || !rv2 || rd2 !== old_l) begin
            errors++;
            $display("FAIL hazard_next: got %h / %h want %h / %h", rd1, rd2, new_l, old_l);
        end
        step();
        checks++;
        if (!rv2 || rd2 !== new_l) begin
            errors++;
            $display("FAIL hazard_new_lat2: got v=%b %h want %h", rv2, rd2, new_l);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        line_t d1, d2;
        logic v1, v2;
        write_line(4'd4, 1'b0, 1'b1, 8'h00, rand_line());
        do_reset();
        for (int i = 0; i < 9; i++) step();
        checks++;
        if (rdy1 !== 1'b0 || rdy2 !== 1'b0) begin
            errors++;
            $display("FAIL sweep_ready: got %b%b want 00", rdy1, rdy2);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_init(n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL sweep_restart: got %0d cycles want 16", n);
        end
        read_one(4'd4, d1, v1, d2, v2);
        checks++;
        if (!v1 || !v2 || d1 !== '0 || d2 !== '0) begin
            errors++;
            $display("FAIL sweep_cleared: got %h / %h want 0", d1, d2);
        end
        write_line(4'd6, 1'b0, 1'b1, 8'h00, rand_line());
        read_one(4'd6, d1, v1, d2, v2);
        drive(1'b1, 1'b0, 1'b0, 4'd6, 8'h00, '0);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (rv1 !== 1'b0 || rv2 !== 1'b0 || rd1 !== '0 || rd2 !== '0) begin
            errors++;
            $display("FAIL read_drop: got v=%b%b %h / %h want v=00 0", rv1, rv2, rd1, rd2);
        end
        step();
        checks++;
        if (rv2 !== 1'b0 || rd2 !== '0) begin
            errors++;
            $display("FAIL read_drop_lat2: got v=%b %h want v=0 0", rv2, rd2);
        end
        wait_init(n);
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL reinit_len: got %0d more cycles want 15", n);
        end
    endtask

    task automatic test_random();
        localparam int N = 80;
        logic  rv_e [N+2];
        line_t rd_e [N+2];
        line_t h1, h2, d;
        logic  v, r, w, f;
        logic [3:0] ad;
        logic [7:0] b;
        h1 = rd1;
        h2 = rd2;
        for (int k = 0; k < N + 2; k++) begin
            rv_e[k] = 1'b0;
            rd_e[k] = '0;
            if (k < N) begin
                v  = ($urandom_range(0, 3) != 0);
                r  = $urandom_range(0, 1) == 1;
                w  = $urandom_range(0, 1) == 1;
                f  = $urandom_range(0, 3) == 0;
                ad = 4'($urandom_range(0, 3));
                b  = 8'($urandom);
                d  = rand_line();
                if (v) drive(r, w, f, ad, b, d);
                else idle();
                if (v) begin
                    rv_e[k] = r;
                    rd_e[k] = mem_m[ad];
                    mem_m[ad] = merge(mem_m[ad], d, b, w, f);
                end
            end else begin
                idle();
            end
            step();
            if (k >= 1) begin
                if (rv_e[k-1]) h1 = rd_e[k-1];
                checks++;
                if (rv1 !== rv_e[k-1] || rd1 !== h1) begin
                    errors++;
                    $display("FAIL rand_lat1 k=%0d: got v=%b %h want v=%b %h", k, rv1, rd1, rv_e[k-1], h1);
                end
            end
            if (k >= 2) begin
                if (rv_e[k-2]) h2 = rd_e[k-2];
                checks++;
                if (rv2 !== rv_e[k-2] || rd2 !== h2) begin
                    errors++;
                    $display("FAIL rand_lat2 k=%0d: got v=%b %h want v=%b %h", k, rv2, rd2, rv_e[k-2], h2);
                end
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_word_write();
        test_fill_priority();
        test_back_to_back();
        test_hazard();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors + 1);
        $fatal(1, "timeout");
    end

endmodule
